arb_rr_hold: RTL and testbench
==============================

Name: arb_rr_hold

Overview:
- N-way round-robin arbiter with grant locking, for sharing one datapath resource (bus port, memory bank) between N requesters.
- A granted requester keeps ownership while it holds req, so multi-cycle transfers are not interrupted.
- A hold-limit counter forces rotation when others are waiting, which bounds starvation.
- Sits between requester agents and the shared resource's mux select; gnt_id drives that mux.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, max consecutive grant cycles before forced rotation if another requester is pending; 0 = unlimited hold.
- IDW, $clog2(N), width of gnt_id (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  N  level request per requester; bit i = requester i.
- gnt  output  N  registered one-hot grant, or all zero.
- gnt_valid  output  1  registered; 1 when any gnt bit is set.
- gnt_id  output  IDW  registered index of the current owner; 0 when gnt_valid=0.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high. When sampled high at a clk edge: gnt=0, gnt_valid=0, gnt_id=0, ptr=0, hold_cnt=0, state=IDLE.
  - rst overrides all other inputs, including mid-grant.
- All outputs are registered. Latency from req to gnt is 1 cycle.
- State IDLE (no owner):
  - If req != 0 at an edge, pick the first set bit searching ptr, ptr+1, ... N-1, 0, ... (wrap).
  - Grant it on that edge, set ptr = winner+1 mod N, set hold_cnt=0, go to GRANT.
  - If req == 0, stay in IDLE with outputs zero.
- State GRANT (owner o), evaluated each edge:
  - (a) req[o]=0, others pending: new winner found by search from ptr; grant moves directly to it on this edge, with no idle bubble. ptr and hold_cnt update as in IDLE.
  - (b) req[o]=0, none pending: gnt=0 on this edge, go to IDLE. ptr unchanged.
  - (c) req[o]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and another req bit set: forced release. Winner is searched from ptr; o is excluded because ptr=o+1 and another request is pending.
  - (d) otherwise: keep o. hold_cnt increments, saturating at MAX_HOLD-1.
- hold_cnt counts completed grant cycles of the current owner. A fresh grant starts at 0. With MAX_HOLD=M, a contended owner holds gnt for exactly M cycles.
- Sole requester: never force-released, regardless of MAX_HOLD.
- Owner is never re-granted back-to-back via the search while another requester is pending, which guarantees fairness.
- Requests arriving while the owner holds have no effect until an (a) or (c) decision.
- Requesters must not assume a grant persists once they deassert req. The grant falls 1 cycle after req drops: gnt stays high in the cycle req is low, then clears or moves.
- Width rules:
  - ptr is IDW bits with explicit wrap at N; N need not be a power of two.
  - Search indices are computed modulo N, never by bit overflow.

Decomposition:
- Package arb_pkg:
  - state enum (IDLE, GRANT).
  - function clog2_min1 for the IDW computation.
- Sub-module rr_pick, purely combinational.
  - Inputs: req[N], ptr[IDW].
  - Outputs: found, idx[IDW], onehot[N].
  - Implements the rotating priority encoder via a double-width req vector shifted by ptr.
- arb_rr_hold contains the FSM, ptr, hold_cnt and output registers.

Test Plan:
All scenarios use N=4, MAX_HOLD=4.
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0 during reset. Release rst -> gnt=0001, gnt_id=0 on the next edge.
- Rotation: req=1111, each owner drops its req 2 cycles after being granted, then reasserts -> grant order 0,1,2,3,0 with no idle cycles between owners.
- Forced release: req=0011 held constant -> gnt=0001 for 4 cycles, 0010 for 4 cycles, then 0001, repeating.
- Sole holder: req=0100 for 12 cycles -> gnt=0100 continuously from the second cycle, never released. req->0000 -> gnt=0000 next cycle, state IDLE.
- Handoff: owner 0 drops req in the same cycle req[3] rises (ptr=1, req[1..2]=0) -> gnt=1000, gnt_id=3 on the next edge, gnt_valid stays 1.
- Reset mid-grant: owner 2 at hold_cnt=2, assert rst one cycle with req=1111 -> gnt=0000. After release, first grant is 0001, since ptr was reset to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Provides the FSM state encoding and the width helper used to size index and counter fields.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // ceil(log2(v)), but never below 1 so a field is always at least one bit wide
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((32'sd1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit at or after ptr, wrapping modulo N.
// Purely combinational; the arbiter FSM decides when its result is taken.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx,
    output logic [N-1:0]   onehot
);

    localparam logic [IDW:0] N_W = (IDW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    // Duplicating req lets a plain right shift rotate it so bit 0 is the ptr position.
    assign dbl     = {req, req};
    assign shifted = dbl >> ptr;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (shifted[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
    end

    // ptr and off are both below N, so one conditional subtract wraps the sum.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
    end

    assign idx    = sum[IDW-1:0];
    assign onehot = found ? (N'(1) << idx) : '0;

endmodule

// File: rtl/arb_rr_hold.sv
// N-way round-robin arbiter with grant locking and a hold limit that forces rotation
// when others wait. gnt, gnt_valid and gnt_id are registered; gnt_id drives the resource mux.
module arb_rr_hold
    import arb_pkg::*;
#(
    parameter int  N        = 4,
    parameter int  MAX_HOLD = 8,
    localparam int IDW      = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    localparam int             HCW         = clog2_min1(MAX_HOLD);
    localparam int             HOLD_LAST   = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HCW-1:0] HOLD_LAST_W = HCW'(HOLD_LAST);
    localparam logic [IDW-1:0] LAST_IDX_W  = IDW'(N - 1);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_nxt;
    logic [N-1:0]   gnt_nxt;
    logic           valid_nxt;
    logic [IDW-1:0] id_nxt;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] ptr_after;
    logic           owner_req;
    logic           others;
    logic           take;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign ptr_after = (pick_idx == LAST_IDX_W) ? '0 : pick_idx + IDW'(1);
    assign owner_req = |(req & gnt);
    assign others    = |(req & ~gnt);

    // ptr always sits one past the owner, so a search during GRANT with others
    // pending can never land back on the owner.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        id_nxt    = gnt_id;
        take      = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (others) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        valid_nxt = 1'b0;
                        id_nxt    = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST_W) && others) begin
                    take = 1'b1;
                end else if (hold_cnt != HOLD_LAST_W) begin
                    hold_nxt = hold_cnt + HCW'(1);
                end
            end
        endcase

        if (take) begin
            state_nxt = GRANT;
            gnt_nxt   = pick_onehot;
            valid_nxt = 1'b1;
            id_nxt    = pick_idx;
            ptr_nxt   = ptr_after;
            hold_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
            gnt_id    <= id_nxt;
        end
    end

endmodule

// File: tb/tb_arb_rr_hold.sv
// Self-checking bench for arb_rr_hold (N=4, MAX_HOLD=4): a behavioural model feeds a
// scoreboard queue each cycle, plus directed checks on the scenarios of interest.
module tb_arb_rr_hold;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;

    arb_rr_hold #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_search(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic m_take(input logic [3:0] r);
        int w;
        w       = m_search(r, m_ptr);
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_hold  = 0;
        m_valid = 1'b1;
    endtask

    // Next registered outputs from the spec rules, given the inputs for this edge.
    task automatic model_step(input logic r_rst, input logic [3:0] r);
        bit pend;
        if (r_rst) begin
            m_valid = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (!m_valid) begin
            if (r != 4'b0000) m_take(r);
        end else begin
            pend = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) pend = 1'b1;
            if (!r[m_owner]) begin
                if (pend) m_take(r);
                else begin
                    m_valid = 1'b0;
                    m_owner = 0;
                end
            end else if (m_hold == MH - 1 && pend) begin
                m_take(r);
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic drive(input logic r_rst, input logic [3:0] r);
        exp_t e;
        rst = r_rst;
        req = r;
        model_step(r_rst, r);
        e.gnt = m_valid ? (4'b0001 << m_owner) : 4'b0000;
        e.vld = m_valid;
        e.id  = m_valid ? 2'(m_owner) : 2'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_gnt", 32'(gnt), 32'(e.gnt));
        check("sb_vld", 32'(gnt_valid), 32'(e.vld));
        check("sb_id", 32'(gnt_id), 32'(e.id));
    endtask

    initial begin
        logic [3:0] rr;
        m_valid = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        rst = 1'b1;
        req = 4'b0000;

        // Reset with all requesting
        drive(1'b1, 4'b1111);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_vld", 32'(gnt_valid), 32'h0);
        drive(1'b1, 4'b1111);
        check("rst_gnt2", 32'(gnt), 32'h0);
        drive(1'b0, 4'b1111);
        check("rel_gnt", 32'(gnt), 32'b0001);
        check("rel_id", 32'(gnt_id), 32'd0);

        // Rotation: each owner drops req after two granted cycles
        for (int o = 0; o < 4; o++) begin
            drive(1'b0, 4'b1111);
            check("rot_keep", 32'(gnt), 32'(4'b0001 << o));
            drive(1'b0, 4'b1111 & ~(4'b0001 << o));
            check("rot_next", 32'(gnt), 32'(4'b0001 << ((o + 1) % 4)));
            check("rot_vld", 32'(gnt_valid), 32'd1);
        end

        // Forced release between two constant requesters
        drive(1'b1, 4'b0000);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 4'b0011);
            check("forced", 32'(gnt), ((((k - 1) / 4) % 2) != 0) ? 32'b0010 : 32'b0001);
        end

        // Sole holder is never forced off
        drive(1'b1, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 4'b0100);
            check("sole", 32'(gnt), 32'b0100);
        end
        drive(1'b0, 4'b0000);
        check("sole_drop", 32'(gnt), 32'h0);
        check("sole_drop_vld", 32'(gnt_valid), 32'h0);
        drive(1'b0, 4'b0010);
        check("idle_regrant", 32'(gnt), 32'b0010);

        // Direct handoff with no idle bubble
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0001);
        drive(1'b0, 4'b1000);
        check("handoff_gnt", 32'(gnt), 32'b1000);
        check("handoff_id", 32'(gnt_id), 32'd3);
        check("handoff_vld", 32'(gnt_valid), 32'd1);

        // Reset in the middle of a grant
        drive(1'b1, 4'b0000);
        for (int k = 0; k < 3; k++) drive(1'b0, 4'b0100);
        check("mid_owner", 32'(gnt), 32'b0100);
        drive(1'b1, 4'b1111);
        check("mid_rst", 32'(gnt), 32'h0);
        drive(1'b0, 4'b1111);
        check("mid_after", 32'(gnt), 32'b0001);

        // Randomised traffic with requests held for a few cycles at a time
        rr = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
